// File: rtl/mcu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// mcu_irq_arbiter : edge-captured interrupt sources, round-robin grant over MCU byte link
// Revision 1.0
// ============================================================================
module mcu_irq_arbiter #(
  parameter int         NSRC     = 4,
  parameter logic [7:0] CMD_IRQ  = 8'h05,
  parameter logic [7:0] CMD_MASK = 8'h06
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            data_in_strobe,
  input  logic            data_in_start,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  input  logic [NSRC-1:0] src_irq,
  output logic [NSRC-1:0] src_iack,
  output logic            mcu_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IRQ  = 2'd1,
    ST_MASK = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      idx_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] mask_q;
  logic [2:0]      last_grant_q;
  logic [2:0]      gnt_id_q;
  logic            gnt_v_q;
  logic [7:0]      data_out_q;
  logic [NSRC-1:0] src_iack_q;
  logic            mcu_irq_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] clr;
  logic [2:0]      winner;
  logic            found;
  logic            ack_now;

  assign rise = src_irq & ~src_q;
  assign cand = pending_q & mask_q;

  // Sources above the last grant take priority; otherwise the lowest index wins.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && cand[i] && (3'(i) > last_grant_q)) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!found && cand[i]) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  assign ack_now = data_in_strobe && !data_in_start && (state_q == ST_IRQ) &&
                   (idx_q == 4'd0) && gnt_v_q;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      clr[i] = ack_now && (gnt_id_q == 3'(i));
    end
  end

  // A rise in the same cycle as the ack keeps the bit set.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      src_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      last_grant_q <= 3'(NSRC - 1);
      gnt_id_q     <= 3'd0;
      gnt_v_q      <= 1'b0;
      data_out_q   <= 8'h00;
      src_iack_q   <= '0;
      mcu_irq_q    <= 1'b0;
    end else begin
      src_q      <= src_irq;
      pending_q  <= pending_d;
      mcu_irq_q  <= |cand;
      src_iack_q <= clr;
      if (data_in_strobe) begin
        if (data_in_start) begin
          idx_q <= 4'd0;
          if (data_in == CMD_IRQ) begin
            state_q    <= ST_IRQ;
            gnt_id_q   <= winner;
            gnt_v_q    <= |cand;
            data_out_q <= {|cand, 4'b0000, winner};
          end else if (data_in == CMD_MASK) begin
            state_q <= ST_MASK;
          end else begin
            state_q <= ST_IDLE;
          end
        end else begin
          if (idx_q != 4'hF) idx_q <= idx_q + 4'd1;
          case (state_q)
            ST_IRQ: begin
              if (idx_q == 4'd0) begin
                if (gnt_v_q) last_grant_q <= gnt_id_q;
                data_out_q <= 8'(pending_q);
              end else begin
                data_out_q <= 8'h00;
              end
            end
            ST_MASK: begin
              if (idx_q == 4'd0) begin
                mask_q     <= data_in[NSRC-1:0];
                data_out_q <= 8'(mask_q);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign data_out = data_out_q;
  assign src_iack = src_iack_q;
  assign mcu_irq  = mcu_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mcu_irq_arbiter : scoreboarded bench for mcu_irq_arbiter against a cycle reference model
// Revision 1.0
// ============================================================================
module tb_mcu_irq_arbiter;
  localparam int NSRC = 4;
  localparam int FULL = (1 << NSRC) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            strobe = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      din = 8'h00;
  logic [7:0]      dout;
  logic [NSRC-1:0] src = '0;
  logic [NSRC-1:0] iack;
  logic            irq;

  always #5 clk = ~clk;

  mcu_irq_arbiter #(.NSRC(NSRC), .CMD_IRQ(8'h05), .CMD_MASK(8'h06)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in_strobe(strobe),
    .data_in_start (start),
    .data_in       (din),
    .data_out      (dout),
    .src_irq       (src),
    .src_iack      (iack),
    .mcu_irq       (irq)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]      d;
    logic [NSRC-1:0] a;
    logic            i;
  } exp_t;
  exp_t sb[$];

  // Reference model state: bitmasks and small integers
  int m_pend, m_mask, m_lg, m_prev, m_st, m_idx, m_gid, m_gv, m_dout, m_iack, m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_mask = FULL; m_lg = NSRC - 1; m_prev = 0;
    m_st = 0; m_idx = 0; m_gid = 0; m_gv = 0; m_dout = 0; m_iack = 0; m_irq = 0;
  endfunction

  function automatic void model_step(input bit stb, input bit st, input int d, input int s);
    int cand, win, gv, clr, rise, newmask;
    cand    = m_pend & m_mask;
    win     = 0;
    gv      = (cand != 0) ? 1 : 0;
    clr     = 0;
    rise    = s & ~m_prev & FULL;
    newmask = m_mask;
    for (int k = 1; k <= NSRC; k++) begin
      int j;
      j = (m_lg + k) % NSRC;
      if (((cand >> j) & 1) == 1) begin
        win = j;
        break;
      end
    end
    if (stb) begin
      if (st) begin
        m_idx = 0;
        if (d == 5) begin
          m_st = 1; m_gid = win; m_gv = gv; m_dout = (gv << 7) | win;
        end else if (d == 6) begin
          m_st = 2;
        end else begin
          m_st = 0;
        end
      end else begin
        if (m_st == 1 && m_idx == 0) begin
          if (m_gv != 0) begin
            clr  = 1 << m_gid;
            m_lg = m_gid;
          end
          m_dout = m_pend;
        end else if (m_st == 1) begin
          m_dout = 0;
        end else if (m_st == 2 && m_idx == 0) begin
          m_dout  = m_mask;
          newmask = d & FULL;
        end
        if (m_idx < 15) m_idx++;
      end
    end
    m_iack = clr;
    m_pend = (m_pend & ~clr) | rise;
    m_mask = newmask;
    m_prev = s;
    m_irq  = gv;
    sb.push_back(exp_t'{d: m_dout[7:0], a: m_iack[NSRC-1:0], i: m_irq[0]});
  endfunction

  // Monitor: one expected response per clocked cycle, compared on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data_out", dout, e.d);
        check("sb_src_iack", iack, e.a);
        check("sb_mcu_irq", irq, e.i);
      end
    end
  end

  task automatic step(input bit stb, input bit st, input logic [7:0] d);
    strobe = stb; start = st; din = d;
    model_step(stb, st, int'(d), int'(src));
    @(posedge clk);
    #1;
    strobe = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic xfer(input logic [7:0] cmd, input int n, input logic [7:0] d);
    step(1'b1, 1'b1, cmd);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    src     = '0;
    model_reset();
    #1;
    check("rst_data_out", dout, 8'h00);
    check("rst_src_iack", iack, 0);
    check("rst_mcu_irq", irq, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Edge capture latency; a held level is one event only
    src = 4'b0100;
    step(1'b0, 1'b0, 8'h00);
    check("t1_irq_n1", irq, 0);
    step(1'b0, 1'b0, 8'h00);
    check("t1_irq_n2", irq, 1);
    idle(4);
    xfer(8'h05, 1, 8'h00);
    check("t1_snapshot", dout, 8'h04);
    idle(2);
    check("t1_no_second", irq, 0);

    // Round robin from last_grant=3 over pending 1011
    do_reset();
    src = 4'b1011;
    idle(3);
    step(1'b1, 1'b1, 8'h05); check("t2_gnt0", dout, 8'h80);
    step(1'b1, 1'b0, 8'h00); check("t2_ack0", iack, 4'b0001);
    step(1'b1, 1'b1, 8'h05); check("t2_gnt1", dout, 8'h81);
    step(1'b1, 1'b0, 8'h00); check("t2_ack1", iack, 4'b0010);
    step(1'b1, 1'b1, 8'h05); check("t2_gnt3", dout, 8'h83);
    step(1'b1, 1'b0, 8'h00); check("t2_ack3", iack, 4'b1000);
    step(1'b1, 1'b1, 8'h05); check("t2_gnt_none", dout, 8'h00);
    check("t2_irq_low", irq, 0);
    step(1'b1, 1'b0, 8'h00); check("t2_no_ack", iack, 4'b0000);

    // Masking
    do_reset();
    xfer(8'h06, 1, 8'h0E);
    src = 4'b0001;
    idle(3);
    check("t3_masked_irq", irq, 0);
    xfer(8'h06, 1, 8'h0F);
    check("t3_old_mask", dout, 8'h0E);
    check("t3_irq_pre", irq, 0);
    idle(1);
    check("t3_irq_unmask", irq, 1);

    // Rise on src 1 in the same cycle as its ack
    src = 4'b0011; idle(1);
    src = 4'b0001; idle(1);
    xfer(8'h05, 1, 8'h00);
    step(1'b1, 1'b1, 8'h05); check("t4_gnt1", dout, 8'h81);
    src = 4'b0011;
    step(1'b1, 1'b0, 8'h00); check("t4_ack1", iack, 4'b0010);
    idle(1);
    check("t4_irq_held", irq, 1);
    step(1'b1, 1'b1, 8'h05); check("t4_still_pending", dout, 8'h81);

    // Abort and unknown command
    do_reset();
    src = 4'b0100;
    idle(3);
    step(1'b1, 1'b1, 8'h05); check("t5_gnt", dout, 8'h82);
    step(1'b1, 1'b1, 8'h00); check("t5_unknown_keep", dout, 8'h82);
    step(1'b1, 1'b0, 8'h33); check("t5_no_ack", iack, 4'b0000);
    check("t5_idle_keep", dout, 8'h82);
    step(1'b1, 1'b1, 8'h05); check("t5_regrant", dout, 8'h82);
    step(1'b1, 1'b0, 8'h00); check("t5_ack", iack, 4'b0100);

    // Asynchronous reset mid-transfer with everything pending
    src = 4'b1111;
    idle(3);
    step(1'b1, 1'b1, 8'h05);
    do_reset();
    xfer(8'h06, 1, 8'h5A);
    check("t6_mask_reset", dout, 8'h0F);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) src[$urandom_range(0, NSRC - 1)] ^= 1'b1;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        step(1'b0, 1'b0, 8'($urandom));
      end else if (r < 5) begin
        int c;
        c = $urandom_range(0, 3);
        step(1'b1, 1'b1, (c < 2) ? 8'h05 : (c == 2) ? 8'h06 : 8'($urandom));
      end else begin
        step(1'b1, 1'b0, 8'($urandom));
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
